// File: rtl/calc2_dispatch_pkg.sv
// Shared types and constants for the CALC2 command dispatcher.
// Issue FSM states, response entries and the fixed CALC2 encodings live here.
package calc2_dispatch_pkg;

    localparam int RSP_ID_W   = 4;
    localparam int RSP_DATA_W = 32;
    localparam int TAG_W      = 2;

    localparam logic [1:0] RESP_TIMEOUT = 2'd3;
    localparam logic [3:0] CMD_NOP      = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE1,
        ISSUE2
    } issue_state_e;

    typedef struct packed {
        logic [RSP_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [RSP_DATA_W-1:0] data;
    } rsp_t;

    // The tag rides along so the drain side knows which table entry to free.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        rsp_t             rsp;
    } rsp_ent_t;

endpackage

// File: rtl/calc2_rsp_fifo.sv
// Per-port synchronous FIFO of response entries awaiting upstream delivery.
module calc2_rsp_fifo
    import calc2_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         c_clk,
    input  logic                         reset,
    input  logic                         push,
    input  rsp_ent_t                     push_data,
    input  logic                         pop,
    output rsp_ent_t                     head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rsp_ent_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/calc2_dispatch.sv
// Round-robin dispatcher from one ID-tagged command stream onto the four CALC2 ports.
// Optional per-tag watchdog: define CALC2_DISPATCH_TIMEOUT_EN.
module calc2_dispatch
    import calc2_dispatch_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int TAGS_PER_PORT = 4,
    parameter int DATA_W        = RSP_DATA_W,
    parameter int ID_W          = RSP_ID_W,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  in_cmd,
    input  logic [DATA_W-1:0]           in_op1,
    input  logic [DATA_W-1:0]           in_op2,
    input  logic [ID_W-1:0]             in_id,
    output logic [NUM_PORTS*4-1:0]      req_cmd_in,
    output logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    output logic [NUM_PORTS*2-1:0]      req_tag_in,
    input  logic [NUM_PORTS*2-1:0]      out_resp,
    input  logic [NUM_PORTS*DATA_W-1:0] out_data,
    input  logic [NUM_PORTS*2-1:0]      out_tag,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [1:0]                  rsp_resp,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        err_spurious
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int FCNT_W = $clog2(TAGS_PER_PORT + 1);

    if (TAGS_PER_PORT != 4 || NUM_PORTS < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("calc2_dispatch: unsupported parameter set");
    end

    function automatic logic [PORT_W-1:0] rr_idx(input logic [PORT_W-1:0] base, input int unsigned off);
        return PORT_W'((32'(base) + off) % 32'(NUM_PORTS));
    endfunction

    issue_state_e state, state_nx;
    logic                     run;
    logic [PORT_W-1:0]        iss_rr, port_q, alloc_port;
    logic [TAG_W-1:0]         tag_q, alloc_tag;
    logic [3:0]               cmd_q;
    logic [DATA_W-1:0]        op1_q, op2_q;
    logic                     alloc_ok, accept;

    logic [NUM_PORTS-1:0][TAGS_PER_PORT-1:0] busy, pend;
    logic [ID_W-1:0]          id_tab [NUM_PORTS][TAGS_PER_PORT];

    logic [NUM_PORTS-1:0]     cap_push, spur, fifo_pop, fifo_empty;
    rsp_ent_t                 push_ent [NUM_PORTS];
    rsp_ent_t                 fifo_head [NUM_PORTS];
    logic [FCNT_W-1:0]        fifo_cnt [NUM_PORTS];

    logic [PORT_W-1:0]        drn_rr, rr_sel, sel, sel_q;
    logic                     rr_any, hold, drain;

    always_comb begin
        alloc_ok   = 1'b0;
        alloc_port = '0;
        alloc_tag  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!alloc_ok && !(&busy[rr_idx(iss_rr, i)])) begin
                alloc_ok   = 1'b1;
                alloc_port = rr_idx(iss_rr, i);
            end
        end
        for (int unsigned t = TAGS_PER_PORT; t > 0; t--) begin
            if (!busy[alloc_port][t-1]) alloc_tag = TAG_W'(t - 1);
        end
    end

    // run holds in_ready low until the first edge after reset release.
    assign in_ready = run && alloc_ok && (state != ISSUE1);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nx    = state;
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
        case (state)
            IDLE: if (accept) state_nx = ISSUE1;
            ISSUE1: begin
                state_nx = ISSUE2;
                req_cmd_in[int'(port_q)*4 +: 4]           = cmd_q;
                req_data_in[int'(port_q)*DATA_W +: DATA_W] = op1_q;
                req_tag_in[int'(port_q)*2 +: 2]           = tag_q;
            end
            ISSUE2: begin
                state_nx = accept ? ISSUE1 : IDLE;
                req_cmd_in[int'(port_q)*4 +: 4]           = CMD_NOP;
                req_data_in[int'(port_q)*DATA_W +: DATA_W] = op2_q;
                req_tag_in[int'(port_q)*2 +: 2]           = tag_q;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            run    <= 1'b0;
            iss_rr <= '0;
            port_q <= '0;
            tag_q  <= '0;
            cmd_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
        end else begin
            state <= state_nx;
            run   <= 1'b1;
            if (accept) begin
                port_q <= alloc_port;
                tag_q  <= alloc_tag;
                cmd_q  <= in_cmd;
                op1_q  <= in_op1;
                op2_q  <= in_op2;
                iss_rr <= rr_idx(alloc_port, 1);
            end
        end
    end

`ifdef CALC2_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]  to_cnt [NUM_PORTS][TAGS_PER_PORT];
    logic [NUM_PORTS-1:0] to_hit;
    logic [TAG_W-1:0]  to_tag [NUM_PORTS];
`endif

    // pend marks tags still owed a response; busy stays set until the drain.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            cap_push[p] = 1'b0;
            spur[p]     = 1'b0;
            push_ent[p] = '0;
            if (out_resp[p*2 +: 2] != 2'd0) begin
                if (pend[p][out_tag[p*2 +: 2]]) begin
                    cap_push[p]          = 1'b1;
                    push_ent[p].tag      = out_tag[p*2 +: 2];
                    push_ent[p].rsp.id   = id_tab[p][out_tag[p*2 +: 2]];
                    push_ent[p].rsp.resp = out_resp[p*2 +: 2];
                    push_ent[p].rsp.data = out_data[p*DATA_W +: DATA_W];
                end else begin
                    spur[p] = 1'b1;
                end
            end
`ifdef CALC2_DISPATCH_TIMEOUT_EN
            to_hit[p] = 1'b0;
            to_tag[p] = '0;
            for (int unsigned t = TAGS_PER_PORT; t > 0; t--) begin
                if (pend[p][t-1] && to_cnt[p][t-1] == CNT_W'(TIMEOUT_CYC)) begin
                    to_hit[p] = 1'b1;
                    to_tag[p] = TAG_W'(t - 1);
                end
            end
            // A real response takes the FIFO write port; the expired tag retries next cycle.
            if (!cap_push[p] && to_hit[p]) begin
                cap_push[p]          = 1'b1;
                push_ent[p].tag      = to_tag[p];
                push_ent[p].rsp.id   = id_tab[p][to_tag[p]];
                push_ent[p].rsp.resp = RESP_TIMEOUT;
                push_ent[p].rsp.data = '0;
            end
`endif
        end
    end

`ifdef CALC2_DISPATCH_TIMEOUT_EN
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++)
                for (int unsigned t = 0; t < TAGS_PER_PORT; t++) to_cnt[p][t] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                for (int unsigned t = 0; t < TAGS_PER_PORT; t++) begin
                    if (accept && alloc_port == PORT_W'(p) && alloc_tag == TAG_W'(t))
                        to_cnt[p][t] <= '0;
                    else if (pend[p][t] && to_cnt[p][t] != CNT_W'(TIMEOUT_CYC))
                        to_cnt[p][t] <= to_cnt[p][t] + CNT_W'(1);
                end
            end
        end
    end
`endif

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy         <= '0;
            pend         <= '0;
            err_spurious <= 1'b0;
            for (int unsigned p = 0; p < NUM_PORTS; p++)
                for (int unsigned t = 0; t < TAGS_PER_PORT; t++) id_tab[p][t] <= '0;
        end else begin
            if (|spur) err_spurious <= 1'b1;
            for (int unsigned p = 0; p < NUM_PORTS; p++)
                if (cap_push[p]) pend[p][push_ent[p].tag] <= 1'b0;
            if (drain) busy[sel][fifo_head[sel].tag] <= 1'b0;
            if (accept) begin
                busy[alloc_port][alloc_tag]   <= 1'b1;
                pend[alloc_port][alloc_tag]   <= 1'b1;
                id_tab[alloc_port][alloc_tag] <= in_id;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc2_rsp_fifo #(.DEPTH(TAGS_PER_PORT)) u_fifo (
            .c_clk     (c_clk),
            .reset     (reset),
            .push      (cap_push[p]),
            .push_data (push_ent[p]),
            .pop       (fifo_pop[p]),
            .head      (fifo_head[p]),
            .empty     (fifo_empty[p]),
            .count     (fifo_cnt[p])
        );

        assert property (@(posedge c_clk) disable iff (!reset)
            !(cap_push[p] && !fifo_pop[p] && fifo_cnt[p] == FCNT_W'(TAGS_PER_PORT)));
    end

    // A stalled response locks its port so a newly filled FIFO cannot swap the payload.
    always_comb begin
        rr_any = 1'b0;
        rr_sel = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!rr_any && !fifo_empty[rr_idx(drn_rr, i)]) begin
                rr_any = 1'b1;
                rr_sel = rr_idx(drn_rr, i);
            end
        end
        sel       = hold ? sel_q : rr_sel;
        rsp_valid = hold || rr_any;
        rsp_id    = '0;
        rsp_resp  = '0;
        rsp_data  = '0;
        if (rsp_valid) begin
            rsp_id   = fifo_head[sel].rsp.id;
            rsp_resp = fifo_head[sel].rsp.resp;
            rsp_data = fifo_head[sel].rsp.data;
        end
        for (int unsigned p = 0; p < NUM_PORTS; p++)
            fifo_pop[p] = rsp_valid && rsp_ready && (sel == PORT_W'(p));
    end

    assign drain = rsp_valid && rsp_ready;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            drn_rr <= '0;
            hold   <= 1'b0;
            sel_q  <= '0;
        end else begin
            hold  <= rsp_valid && !rsp_ready;
            sel_q <= sel;
            if (drain) drn_rr <= rr_idx(sel, 1);
        end
    end

endmodule

// File: tb/tb_calc2_dispatch.sv
// Directed self-checking bench for calc2_dispatch; CALC2 replies are driven by hand.
// Build with CALC2_DISPATCH_TIMEOUT_EN to exercise the watchdog path.
module tb_calc2_dispatch;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int IW = 4;
`ifdef CALC2_DISPATCH_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 255;
`endif

    logic             c_clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_cmd;
    logic [DW-1:0]    in_op1, in_op2;
    logic [IW-1:0]    in_id;
    logic [NP*4-1:0]  req_cmd_in;
    logic [NP*DW-1:0] req_data_in;
    logic [NP*2-1:0]  req_tag_in;
    logic [NP*2-1:0]  out_resp;
    logic [NP*DW-1:0] out_data;
    logic [NP*2-1:0]  out_tag;
    logic             rsp_valid, rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [1:0]       rsp_resp;
    logic [DW-1:0]    rsp_data;
    logic             err_spurious;

    int n_cmp = 0;
    int n_err = 0;

    calc2_dispatch #(
        .NUM_PORTS     (NP),
        .TAGS_PER_PORT (4),
        .DATA_W        (DW),
        .ID_W          (IW),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_op1       (in_op1),
        .in_op2       (in_op2),
        .in_id        (in_id),
        .req_cmd_in   (req_cmd_in),
        .req_data_in  (req_data_in),
        .req_tag_in   (req_tag_in),
        .out_resp     (out_resp),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_resp     (rsp_resp),
        .rsp_data     (rsp_data),
        .err_spurious (err_spurious)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_cmd    = '0;
        in_op1    = '0;
        in_op2    = '0;
        in_id     = '0;
        out_resp  = '0;
        out_data  = '0;
        out_tag   = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] id);
        int n = 0;
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_op1   = a;
        in_op2   = b;
        in_id    = id;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("issue_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic reply(input int p, input logic [1:0] tag, input logic [1:0] resp,
                         input logic [31:0] data);
        out_resp[p*2 +: 2]  = resp;
        out_tag[p*2 +: 2]   = tag;
        out_data[p*DW +: DW] = data;
        tick();
        out_resp = '0;
        out_tag  = '0;
        out_data = '0;
    endtask

    function automatic int active_port();
        for (int p = 0; p < NP; p++)
            if (req_cmd_in[p*4 +: 4] != 4'd0) return p;
        return 0;
    endfunction

    initial begin
        int p;
        int n;

        // Reset state
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_cmd", 64'(req_cmd_in), 64'd0);
        chk("rst_req_data", 64'(req_data_in[63:0]), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        tick();
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Single add
        in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd5; in_op2 = 32'd7; in_id = 4'd3;
        tick();
        in_valid = 1'b0;
        chk("add_cmd", 64'(req_cmd_in), 64'h0001);
        chk("add_tag", 64'(req_tag_in), 64'd0);
        chk("add_op1", 64'(req_data_in[31:0]), 64'd5);
        chk("add_issue1_ready", 64'(in_ready), 64'd0);
        tick();
        chk("add_cmd2", 64'(req_cmd_in), 64'd0);
        chk("add_op2", 64'(req_data_in[31:0]), 64'd7);
        tick();
        chk("add_idle_data", 64'(req_data_in[31:0]), 64'd0);
        reply(0, 2'd0, 2'd1, 32'd12);
        chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("add_rsp_id", 64'(rsp_id), 64'd3);
        chk("add_rsp_resp", 64'(rsp_resp), 64'd1);
        chk("add_rsp_data", 64'(rsp_data), 64'd12);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("add_drained", 64'(rsp_valid), 64'd0);

`ifndef CALC2_DISPATCH_TIMEOUT_EN
        // Back-to-back issue until every tag is busy
        do_reset();
        tick();
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_cmd = 4'd2;
            in_op1 = 32'(100 + k); in_op2 = 32'(200 + k); in_id = 4'(k);
            tick();
            p = active_port();
            chk("bb_port", 64'(p), 64'(k % 4));
            chk("bb_tag", 64'(req_tag_in[p*2 +: 2]), 64'(k / 4));
            chk("bb_op1", 64'(req_data_in[p*DW +: DW]), 64'(100 + k));
            tick();
            chk("bb_op2", 64'(req_data_in[p*DW +: DW]), 64'(200 + k));
            chk("bb_ready", 64'(in_ready), (k < 15) ? 64'd1 : 64'd0);
        end
        in_cmd = 4'd5; in_op1 = 32'h77; in_op2 = 32'h88; in_id = 4'hA;
        tick();
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_noissue", 64'(req_cmd_in), 64'd0);
        tick();
        chk("full_ready2", 64'(in_ready), 64'd0);
        reply(1, 2'd2, 2'd1, 32'h99);
        chk("full_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("full_rsp_id", 64'(rsp_id), 64'd9);
        chk("full_rsp_data", 64'(rsp_data), 64'h99);
        chk("full_still_busy", 64'(in_ready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("freed_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("freed_ready", 64'(in_ready), 64'd1);
        tick();
        p = active_port();
        chk("refill_port", 64'(p), 64'd1);
        chk("refill_tag", 64'(req_tag_in[p*2 +: 2]), 64'd2);
        chk("refill_op1", 64'(req_data_in[p*DW +: DW]), 64'h77);
        tick();
        chk("refill_one_only", 64'(in_ready), 64'd0);
        tick();
        chk("refill_idle", 64'(req_cmd_in), 64'd0);
        in_valid = 1'b0;

        // Simultaneous replies on all ports under back-pressure
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) issue(4'd3, 32'(k), 32'(k + 1), 4'(12 + k));
        for (int k = 0; k < NP; k++) begin
            out_resp[k*2 +: 2]   = 2'd1;
            out_tag[k*2 +: 2]    = 2'd0;
            out_data[k*DW +: DW] = 32'(32'h1000 + k);
        end
        tick();
        out_resp = '0; out_tag = '0; out_data = '0;
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_id", 64'(rsp_id), 64'd12);
            chk("stall_data", 64'(rsp_data), 64'h1000);
            tick();
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < NP; k++) begin
            chk("order_valid", 64'(rsp_valid), 64'd1);
            chk("order_id", 64'(rsp_id), 64'(12 + k));
            chk("order_data", 64'(rsp_data), 64'(32'h1000 + k));
            tick();
        end
        rsp_ready = 1'b0;
        chk("order_empty", 64'(rsp_valid), 64'd0);
`endif

        // Spurious reply with nothing outstanding
        do_reset();
        tick();
        reply(2, 2'd3, 2'd1, 32'hDEAD);
        chk("spur_no_valid", 64'(rsp_valid), 64'd0);
        chk("spur_err", 64'(err_spurious), 64'd1);
        repeat (3) tick();
        chk("spur_sticky", 64'(err_spurious), 64'd1);
        do_reset();
        chk("spur_cleared", 64'(err_spurious), 64'd0);

`ifdef CALC2_DISPATCH_TIMEOUT_EN
        // Watchdog: synthetic resp=3 after TIMEOUT_CYC+1 cycles, late reply is spurious
        tick();
        in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd1; in_op2 = 32'd2; in_id = 4'd6;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 60) begin
            tick();
            n++;
        end
        chk("to_latency", 64'(n), 64'(TO + 1));
        chk("to_resp", 64'(rsp_resp), 64'd3);
        chk("to_data", 64'(rsp_data), 64'd0);
        chk("to_id", 64'(rsp_id), 64'd6);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_err_before", 64'(err_spurious), 64'd0);
        reply(0, 2'd0, 2'd1, 32'd3);
        chk("to_late_no_valid", 64'(rsp_valid), 64'd0);
        chk("to_late_err", 64'(err_spurious), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
